systolic_ctrl: RTL and testbench
================================

# systolic_ctrl

Sequencing controller for the `systolic_4x4` array. It accepts one matrix-multiply job per `start` pulse and streams weights then inputs from a host valid/ready port into the array's serial load interface. It then waits for `valid_out`, runs the store/readout phase, and buffers the 16 results so the host can drain them under backpressure. It sits between the host/DMA side and the `systolic_4x4` instance and is the only driver of the array's control pins.

## Interface
Parameters:
- `N`, 4 — array dimension; a job is N*N = 16 beats per phase
- `DW`, 4 — operand width
- `RW`, 8 — result width
- `TIMEOUT`, 64 — maximum WAIT cycles before abort

Ports:
- `clk`  in  1  — single clock, rising edge
- `reset`  in  1  — synchronous, active-low
- `start`  in  1  — job request; sampled only in IDLE
- `reuse_weights`  in  1  — sampled with `start`; 1 skips the weight phase
- `in_data`  in  DW  — host operand stream, row-major: weights first, then inputs
- `in_valid`  in  1  — host beat valid
- `in_ready`  out  1  — controller accepts a beat
- `out_data`  out  RW  — result stream, row-major
- `out_valid`  out  1  — result beat valid
- `out_ready`  in  1  — host accepts the result beat
- `busy`  out  1  — high in any state other than IDLE
- `done`  out  1  — 1-cycle pulse at job end
- `error`  out  1  — timeout flag; sticky until the next accepted `start`
- `sa_data_in`  out  DW  — to array `data_in`
- `sa_load_weights`  out  1  — to array `load_weights`
- `sa_load_inputs`  out  1  — to array `load_inputs`
- `sa_store_outputs`  out  1  — to array `store_outputs`
- `sa_results`  in  RW  — from array `results`
- `sa_valid_out`  in  1  — from array `valid_out`

## Operation
- States: IDLE, LOAD_W, GAP_W, LOAD_I, GAP_I, WAIT, STORE, DRAIN, FIN.
- IDLE: `start`=1 → LOAD_W, or LOAD_I if `reuse_weights`=1. Clears `error` and the beat counter.
- LOAD_W / LOAD_I:
  - `in_ready`=1.
  - On a handshake (`in_valid & in_ready`), in the same cycle: `sa_data_in`=`in_data`, `sa_load_weights`/`sa_load_inputs`=1, counter++.
  - On cycles without a handshake, the load strobe is 0 and `sa_data_in` holds.
  - After the 16th beat → GAP_W / GAP_I.
- GAP_W / GAP_I: one idle cycle with all strobes 0, then → LOAD_I or WAIT respectively.
- WAIT:
  - `sa_valid_out`=1 → STORE.
  - The cycle counter reaching `TIMEOUT` → FIN with `error`=1. STORE is not entered.
- STORE:
  - `sa_store_outputs`=1 for 17 cycles: 1 lead cycle, then 16 capture cycles.
  - On each capture cycle, `sa_results` is written into the internal 16×RW buffer at the index held by the counter.
  - The array cannot be stalled, so capture happens unconditionally.
  - → DRAIN.
- DRAIN:
  - `out_valid`=1 and `out_data`=buf[rd_idx].
  - rd_idx advances on `out_valid & out_ready`.
  - While `out_ready`=0, `out_data` holds stable.
  - After the 16th handshake → FIN.
- FIN: `done`=1 for one cycle → IDLE.
- `start` while `busy`=1 is ignored; it is neither queued nor does it affect the job in progress.
- `in_ready`=0 outside LOAD states. Host beats offered there are not consumed.
- `sa_valid_out` outside WAIT is ignored.
- `reset` low mid-job aborts immediately. The buffer contents are don't-care after reset, but `out_valid` must be 0.

## Timing
- Reset values: all outputs 0, with `sa_data_in`=0 and `out_data`=0. State is IDLE and `error`=0.
- `start` cycle T: `in_ready` is high from T+1.
- Load strobes are combinational on the handshake, registered into the array on the same edge.
- Minimum job length, no stalls, W phase included:
  - 1 (start) + 16 (LOAD_W) + 1 (GAP_W) + 16 (LOAD_I) + 1 (GAP_I) + WAIT + 17 (STORE) + 16 (DRAIN) + 1 (FIN).
- WAIT entry: first cycle after GAP_I. `sa_valid_out` seen at cycle W → `sa_store_outputs` rises at W+1.
- Capture: the first capture edge is the 2nd cycle of `sa_store_outputs`. `sa_store_outputs` falls after the 16th capture.
- First `out_valid` is on the cycle after STORE ends.
- `done` is asserted on the cycle after the last DRAIN handshake. `busy` falls the cycle after `done`.
- Timeout:
  - WAIT lasts exactly `TIMEOUT` cycles without `sa_valid_out`.
  - `done` and `error` both rise on the next cycle.
  - `error` stays high in IDLE until the next `start`.

## Test plan
- Nominal job:
  - Stimulus: weights all 1, inputs identity, both streamed with no gaps. The behavioural array model raises `valid_out` 5 cycles into WAIT and returns results 1..16.
  - Response: `sa_load_weights` and `sa_load_inputs` each high exactly 16 cycles, with one 0 gap cycle after each phase. `out_data` sequence is 1..16, `done` pulses once, `error`=0.
- Input gaps: `in_valid` toggled every other cycle → each load strobe high exactly 16 cycles, each with the matching `sa_data_in`. The phase takes 32 cycles.
- Weight reuse: `start` with `reuse_weights`=1 → `sa_load_weights` never asserts, and the first 16 host beats appear on `sa_load_inputs`.
- Output backpressure: `out_ready` held low for 3 cycles after beat 5 → `out_data`=6 stays stable throughout. All 16 beats are delivered in order with none lost or duplicated.
- Timeout: `sa_valid_out` held at 0 → after exactly 64 WAIT cycles, `error`=1 and `done` pulses. `sa_store_outputs` is never asserted, `out_valid` stays 0, and `busy` falls.
- Reset and busy-start:
  - `reset`=0 for 1 cycle at beat 7 of LOAD_I → on the next cycle every output is 0 and the state is IDLE.
  - A subsequent full job completes as in the nominal scenario.
  - A `start` pulsed mid-job is ignored.

Source files
------------

// File: rtl/systolic_ctrl.sv
// Sequencing controller for systolic_4x4: streams weights/inputs into the array's serial
// load port, runs the store phase, buffers the results and drains them under backpressure.
module systolic_ctrl #(
  parameter int unsigned N       = 4,
  parameter int unsigned DW      = 4,
  parameter int unsigned RW      = 8,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_start,
  input  logic          i_reuse_weights,
  input  logic [DW-1:0] i_in_data,
  input  logic          i_in_valid,
  output logic          o_in_ready,
  output logic [RW-1:0] o_out_data,
  output logic          o_out_valid,
  input  logic          i_out_ready,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_error,
  output logic [DW-1:0] o_sa_data_in,
  output logic          o_sa_load_weights,
  output logic          o_sa_load_inputs,
  output logic          o_sa_store_outputs,
  input  logic [RW-1:0] i_sa_results,
  input  logic          i_sa_valid_out
);

  localparam int unsigned Beats  = N * N;
  localparam int unsigned CntMax = (TIMEOUT > Beats) ? TIMEOUT : Beats;
  localparam int unsigned CW     = $clog2(CntMax + 1);
  localparam int unsigned IW     = (Beats > 1) ? $clog2(Beats) : 1;

  localparam logic [CW-1:0] LastBeat  = CW'(Beats - 1);
  localparam logic [CW-1:0] StoreLast = CW'(Beats);
  localparam logic [CW-1:0] WaitLast  = CW'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    StIdle, StLoadW, StGapW, StLoadI, StGapI, StWait, StStore, StDrain, StFin
  } state_e;

  state_e          r_state;
  state_e          w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic            r_error;
  logic [DW-1:0]   r_sa_data;
  logic [RW-1:0]   r_buf [Beats];

  logic            w_loading;
  logic            w_in_hs;
  logic            w_out_hs;
  logic            w_last_beat;
  logic            w_timeout;
  logic [IW-1:0]   w_cap_idx;
  logic [IW-1:0]   w_rd_idx;

  assign w_loading   = (r_state == StLoadW) || (r_state == StLoadI);
  assign w_in_hs     = w_loading & i_in_valid;
  assign w_out_hs    = (r_state == StDrain) & i_out_ready;
  assign w_last_beat = (r_cnt == LastBeat);
  assign w_timeout   = !i_sa_valid_out && (r_cnt == WaitLast);
  // Store cycle 0 is the lead cycle, so capture k lands in slot k-1.
  assign w_cap_idx   = IW'(r_cnt - CW'(1));
  assign w_rd_idx    = r_cnt[IW-1:0];

  always_ff @(posedge i_clk) begin
    if (!i_reset) r_state <= StIdle;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:  if (i_start) w_state_nxt = i_reuse_weights ? StLoadI : StLoadW;
      StLoadW: if (w_in_hs && w_last_beat) w_state_nxt = StGapW;
      StGapW:  w_state_nxt = StLoadI;
      StLoadI: if (w_in_hs && w_last_beat) w_state_nxt = StGapI;
      StGapI:  w_state_nxt = StWait;
      StWait: begin
        if (i_sa_valid_out) w_state_nxt = StStore;
        else if (w_timeout) w_state_nxt = StFin;
      end
      StStore: if (r_cnt == StoreLast) w_state_nxt = StDrain;
      StDrain: if (w_out_hs && w_last_beat) w_state_nxt = StFin;
      StFin:   w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_comb begin
    o_in_ready         = 1'b0;
    o_out_valid        = 1'b0;
    o_out_data         = '0;
    o_done             = 1'b0;
    o_sa_load_weights  = 1'b0;
    o_sa_load_inputs   = 1'b0;
    o_sa_store_outputs = 1'b0;
    o_sa_data_in       = r_sa_data;
    o_busy             = (r_state != StIdle);
    o_error            = r_error;
    unique case (r_state)
      StLoadW: begin
        o_in_ready        = 1'b1;
        o_sa_load_weights = i_in_valid;
        if (i_in_valid) o_sa_data_in = i_in_data;
      end
      StLoadI: begin
        o_in_ready       = 1'b1;
        o_sa_load_inputs = i_in_valid;
        if (i_in_valid) o_sa_data_in = i_in_data;
      end
      StStore: o_sa_store_outputs = 1'b1;
      StDrain: begin
        o_out_valid = 1'b1;
        o_out_data  = r_buf[w_rd_idx];
      end
      StFin:   o_done = 1'b1;
      default: ;
    endcase
  end

  // One counter serves as beat index, wait timer, store phase and drain read index.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_cnt     <= '0;
      r_error   <= 1'b0;
      r_sa_data <= '0;
    end else begin
      if (w_in_hs) r_sa_data <= i_in_data;
      unique case (r_state)
        StIdle: begin
          r_cnt <= '0;
          if (i_start) r_error <= 1'b0;
        end
        StLoadW, StLoadI: begin
          if (w_in_hs) r_cnt <= w_last_beat ? '0 : r_cnt + CW'(1);
        end
        StWait: begin
          if (i_sa_valid_out) begin
            r_cnt <= '0;
          end else if (w_timeout) begin
            r_cnt   <= '0;
            r_error <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        StStore: r_cnt <= (r_cnt == StoreLast) ? '0 : r_cnt + CW'(1);
        StDrain: begin
          if (w_out_hs) r_cnt <= w_last_beat ? '0 : r_cnt + CW'(1);
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  // The array cannot be stalled, so capture is unconditional.
  always_ff @(posedge i_clk) begin
    if (r_state == StStore && r_cnt != '0) r_buf[w_cap_idx] <= i_sa_results;
  end

endmodule

// File: tb/tb_systolic_ctrl.sv
// Self-checking bench for systolic_ctrl: table of job scenarios plus hand-written reset and
// busy-start sequences; a behavioural array model and scoreboards for loads and results.
module tb_systolic_ctrl;

  localparam int N = 4, DW = 4, RW = 8, TIMEOUT = 64;

  logic          clk;
  logic          reset_n, start, reuse_weights, in_valid, out_ready;
  logic [DW-1:0] in_data;
  logic          in_ready, out_valid, busy, done, error;
  logic [RW-1:0] out_data;
  logic [DW-1:0] sa_data_in;
  logic          sa_lw, sa_li, sa_so, sa_valid_out;
  logic [RW-1:0] sa_results;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  systolic_ctrl #(.N(N), .DW(DW), .RW(RW), .TIMEOUT(TIMEOUT)) dut (
    .i_clk(clk), .i_reset(reset_n), .i_start(start), .i_reuse_weights(reuse_weights),
    .i_in_data(in_data), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .o_out_data(out_data), .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_busy(busy), .o_done(done), .o_error(error),
    .o_sa_data_in(sa_data_in), .o_sa_load_weights(sa_lw), .o_sa_load_inputs(sa_li),
    .o_sa_store_outputs(sa_so), .i_sa_results(sa_results), .i_sa_valid_out(sa_valid_out)
  );

  typedef struct packed { logic is_w; logic [DW-1:0] d; } beat_t;
  typedef struct {
    string name; bit reuse; bit gaps; int bp_after; bit no_vo; bit ones_id; bit mid_start;
    int abort_at; int res_base; int exp_lw; int exp_li; int exp_store; int exp_out;
    bit exp_err; int exp_span; int exp_len;
  } job_t;

  beat_t         q_in[$];
  logic [RW-1:0] q_out[$];
  int n_cmp = 0, n_bad = 0, cyc = 0;
  int n_lw, n_li, n_store, n_out, n_done;
  int t_start, t_rdy, t_first_lw, t_last_lw, t_first_li, t_last_li;
  int t_vo, t_st_first, t_st_last, t_ov, t_last_out, t_done;
  bit err_at_done, hs_in;
  logic [DW-1:0] m_last_din;
  int            m_sc, m_base;
  bit            m_en_vo;
  logic          m_vo_nxt;
  logic [RW-1:0] m_res_nxt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
  endtask

  // Negedge monitor: scoreboards plus next-cycle values of the behavioural array model.
  task automatic sample();
    beat_t e;
    cyc++;
    if (!reset_n) begin
      q_in.delete(); q_out.delete();
      m_last_din = '0; m_sc = 0; m_vo_nxt = 1'b0; m_res_nxt = '0; hs_in = 0;
      return;
    end
    hs_in = in_valid && in_ready;
    if (start && !busy && t_start < 0) t_start = cyc;
    if (in_ready && t_rdy < 0) t_rdy = cyc;
    if (sa_lw || sa_li) begin
      if (sa_lw) begin n_lw++; if (t_first_lw < 0) t_first_lw = cyc; t_last_lw = cyc; end
      if (sa_li) begin n_li++; if (t_first_li < 0) t_first_li = cyc; t_last_li = cyc; end
      if (q_in.size() == 0) fail_now("load_extra", "load strobe with no beat pending");
      else begin
        e = q_in.pop_front();
        chk("load_kind", 32'(sa_lw), 32'(e.is_w));
        chk("sa_data_in", 32'(sa_data_in), 32'(e.d));
        m_last_din = e.d;
      end
    end else chk("din_hold", 32'(sa_data_in), 32'(m_last_din));
    if (sa_so) begin
      m_sc++; n_store++;
      if (t_st_first < 0) t_st_first = cyc;
      t_st_last = cyc;
    end else m_sc = 0;
    m_res_nxt = (m_sc >= 1 && m_sc <= 16) ? RW'(m_base + m_sc - 1) : '0;
    if (sa_valid_out && t_vo < 0) t_vo = cyc;
    // valid_out pulses in the 5th WAIT cycle (GAP_I follows the last input beat).
    m_vo_nxt = m_en_vo && n_li == 16 && t_last_li >= 0 && (cyc + 1 == t_last_li + 6);
    if (out_valid) begin
      if (t_ov < 0) t_ov = cyc;
      if (q_out.size() == 0) fail_now("out_extra", "out_valid with no result pending");
      else begin
        chk("out_data", 32'(out_data), 32'(q_out[0]));
        if (out_ready) begin
          void'(q_out.pop_front());
          n_out++;
          t_last_out = cyc;
        end
      end
    end
    if (done) begin n_done++; t_done = cyc; err_at_done = error; end
  endtask

  task automatic step();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    sa_valid_out = m_vo_nxt;
    sa_results   = m_res_nxt;
  endtask

  task automatic run_job(input job_t j);
    logic [DW-1:0] s [32];
    logic [DW-1:0] w, x;
    int nb, beat, k, stall;
    bit aborted;
    beat_t e;
    n_lw = 0; n_li = 0; n_store = 0; n_out = 0; n_done = 0; err_at_done = 0;
    t_start = -1; t_rdy = -1; t_first_lw = -1; t_last_lw = -1; t_first_li = -1;
    t_last_li = -1; t_vo = -1; t_st_first = -1; t_st_last = -1; t_ov = -1;
    t_last_out = -1; t_done = -1;
    nb = j.reuse ? 16 : 32;
    for (int i = 0; i < 16; i++) begin
      w = j.ones_id ? DW'(1) : DW'($urandom_range(0, 15));
      x = j.ones_id ? DW'((i / 4) == (i % 4)) : DW'($urandom_range(0, 15));
      if (j.reuse) s[i] = x;
      else begin s[i] = w; s[16 + i] = x; end
    end
    for (int i = 0; i < nb; i++) begin
      e.is_w = !j.reuse && i < 16;
      e.d    = s[i];
      q_in.push_back(e);
    end
    if (!j.no_vo) for (int i = 0; i < 16; i++) q_out.push_back(RW'(j.res_base + i));
    m_en_vo = !j.no_vo;
    m_base  = j.res_base;

    reuse_weights = j.reuse; start = 1'b1;
    step();
    reuse_weights = 1'b0; start = 1'b0;
    chk({j.name, "_in_ready_t1"}, 32'(in_ready), 32'(1));
    chk({j.name, "_err_clear"}, 32'(error), 32'(0));

    beat = 0; k = 0; stall = 0; aborted = 0;
    for (int c = 0; c < 600; c++) begin
      reset_n  = !(j.abort_at >= 0 && beat == j.abort_at);
      in_valid = (beat < nb) && (!j.gaps || (k % 2) == 0);
      in_data  = (beat < nb) ? s[beat] : '0;
      if (j.bp_after >= 0 && n_out == j.bp_after && stall < 3) begin
        out_ready = 1'b0; stall++;
      end else out_ready = 1'b1;
      start = j.mid_start && (beat == 20 || n_out == 3);
      step();
      if (!reset_n) begin aborted = 1; break; end
      if (hs_in) beat++;
      k++;
      if (n_done > 0) break;
    end
    start = 1'b0; in_valid = 1'b0; reset_n = 1'b1;
    #1;
    if (aborted) begin
      chk({j.name, "_outputs_zero"}, 32'({in_ready, out_data, out_valid, busy, done, error,
          sa_data_in, sa_lw, sa_li, sa_so}), 32'(0));
      chk({j.name, "_idle_no_ready"}, 32'(in_ready | busy), 32'(0));
      return;
    end
    if (n_done == 0) begin
      fail_now({j.name, "_no_done"}, "job did not finish within 600 cycles");
      return;
    end
    chk({j.name, "_busy_fall"}, 32'(busy), 32'(0));
    chk({j.name, "_err_idle"}, 32'(error), 32'(j.exp_err));
    chk({j.name, "_n_lw"}, 32'(n_lw), 32'(j.exp_lw));
    chk({j.name, "_n_li"}, 32'(n_li), 32'(j.exp_li));
    chk({j.name, "_n_store"}, 32'(n_store), 32'(j.exp_store));
    chk({j.name, "_n_out"}, 32'(n_out), 32'(j.exp_out));
    chk({j.name, "_n_done"}, 32'(n_done), 32'(1));
    chk({j.name, "_err_at_done"}, 32'(err_at_done), 32'(j.exp_err));
    chk({j.name, "_q_in_left"}, 32'(q_in.size()), 32'(0));
    chk({j.name, "_q_out_left"}, 32'(q_out.size()), 32'(0));
    chk({j.name, "_rdy_t1"}, 32'(t_rdy), 32'(t_start + 1));
    chk({j.name, "_li_span"}, 32'(t_last_li - t_first_li), 32'(j.exp_span));
    if (j.exp_lw > 0) chk({j.name, "_lw_span"}, 32'(t_last_lw - t_first_lw), 32'(j.exp_span));
    if (j.exp_len > 0) chk({j.name, "_job_len"}, 32'(t_done - t_start + 1), 32'(j.exp_len));
    if (j.no_vo) begin
      chk({j.name, "_wait_len"}, 32'(t_done - t_last_li), 32'(TIMEOUT + 2));
    end else begin
      chk({j.name, "_store_rise"}, 32'(t_st_first), 32'(t_vo + 1));
      chk({j.name, "_first_ov"}, 32'(t_ov), 32'(t_st_last + 1));
      chk({j.name, "_done_time"}, 32'(t_done), 32'(t_last_out + 1));
    end
  endtask

  job_t tbl [5];
  job_t hand;

  initial begin
    reset_n = 1'b0; start = 1'b0; reuse_weights = 1'b0; in_valid = 1'b0; in_data = '0;
    out_ready = 1'b1; sa_valid_out = 1'b0; sa_results = '0;
    step();
    step();
    chk("reset_outputs", 32'({in_ready, out_data, out_valid, busy, done, error, sa_data_in,
        sa_lw, sa_li, sa_so}), 32'(0));
    reset_n = 1'b1;
    step();

    //          name            reuse gaps  bp  no_vo ones  mid  abort base lw  li  st  out err span len
    tbl[0] = '{"nominal",      1'b0, 1'b0, -1, 1'b0, 1'b1, 1'b0, -1,  1,  16, 16, 17, 16, 1'b0, 15, 74};
    tbl[1] = '{"gaps",         1'b0, 1'b1, -1, 1'b0, 1'b0, 1'b0, -1,  32, 16, 16, 17, 16, 1'b0, 30, 0};
    tbl[2] = '{"reuse",        1'b1, 1'b0, -1, 1'b0, 1'b0, 1'b0, -1,  64, 0,  16, 17, 16, 1'b0, 15, 57};
    tbl[3] = '{"backpressure", 1'b0, 1'b0, 5,  1'b0, 1'b1, 1'b0, -1,  1,  16, 16, 17, 16, 1'b0, 15, 77};
    tbl[4] = '{"timeout",      1'b0, 1'b0, -1, 1'b1, 1'b0, 1'b0, -1,  0,  16, 16, 0,  0,  1'b1, 15, 100};
    for (int i = 0; i < 5; i++) begin
      run_job(tbl[i]);
      for (int c = 0; c < 3; c++) step();
      chk({tbl[i].name, "_err_sticky"}, 32'(error), 32'(tbl[i].exp_err));
    end

    // Reset for one cycle at the 7th input beat, then a full job with stray start pulses.
    hand = '{"abort", 1'b0, 1'b0, -1, 1'b0, 1'b1, 1'b0, 22, 1, 0, 0, 0, 0, 1'b0, 0, 0};
    run_job(hand);
    step();
    hand = '{"busy_start", 1'b0, 1'b0, -1, 1'b0, 1'b1, 1'b1, -1, 1, 16, 16, 17, 16, 1'b0, 15, 74};
    run_job(hand);
    for (int c = 0; c < 5; c++) begin
      step();
      chk("no_queued_start", 32'(busy), 32'(0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
